// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - request/status bundle between a FIFO producer/consumer and sync_fifo
//
// Purpose: groups the write/read requests, data and status flags of sync_fifo.
// Signals:
//   wr_en    write request (accepted only when full = 0)
//   rd_en    read request (accepted only when empty = 0)
//   data_in  word written on an accepted write
//   data_out read data (registered or fall-through, see sync_fifo)
//   full     FIFO holds 2^ADDR_WIDTH words
//   empty    FIFO holds 0 words
// Modports: master drives requests/data_in; slave (the FIFO) drives data_out and flags.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;

  modport master (
    output wr_en,
    output rd_en,
    output data_in,
    input  data_out,
    input  full,
    input  empty
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    input  data_in,
    output data_out,
    output full,
    output empty
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with full/empty flags and optional fall-through output
//
// Purpose: buffers DATA_WIDTH-bit words (e.g. RGB565 pixels) between the UART
// assembly path and the TFT writer. Storage is a 2^ADDR_WIDTH-entry register array.
// Ports:
//   clk      single clock, all state changes on the rising edge
//   reset_n  asynchronous active-low reset (pointers and data_out cleared, memory kept)
//   bus      sync_fifo_if.slave: wr_en, rd_en, data_in in; data_out, full, empty out
// Build option:
//   SYNC_FIFO_FWFT_EN  when defined, data_out shows the head word continuously
//                      (first-word-fall-through); otherwise data_out is a register
//                      loaded on each accepted read.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  sync_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the address bits coincide.
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_index;
  logic [ADDR_WIDTH-1:0] rd_index;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] w_head;

  assign wr_index = r_wr_ptr[ADDR_WIDTH-1:0];
  assign rd_index = r_rd_ptr[ADDR_WIDTH-1:0];

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (wr_index == rd_index) &&
                   (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

  // Acceptance uses the pre-edge flags, so a simultaneous write+read on a
  // full FIFO only reads and on an empty FIFO only writes.
  assign w_wr_accept = bus.wr_en && !w_full;
  assign w_rd_accept = bus.rd_en && !w_empty;

  assign w_head = r_mem[rd_index];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_accept) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[wr_index] <= bus.data_in;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible as soon as the FIFO is non-empty; forced to 0 when empty.
  assign bus.data_out = w_empty ? '0 : w_head;
`else
  logic [DATA_WIDTH-1:0] r_data_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
    end else if (w_rd_accept) begin
      r_data_out <= w_head;
    end
  end

  assign bus.data_out = r_data_out;
`endif

  assign bus.full  = w_full;
  assign bus.empty = w_empty;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo (depth 16) against a queue model
module tb_sync_fifo;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic reset_n;

  sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus totals of accepted operations.
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_out;
  int unsigned   wr_total;
  int unsigned   rd_total;
  bit            mon_en;

  int n_cmp;
  int n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    last_out = '0;
    wr_total = 0;
    rd_total = 0;
  endtask

  // One clock of stimulus. Acceptance is decided from the model occupancy
  // before the edge; an accepted read pushes its expected word to exp_q.
  task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d);
    bit acc_w;
    bit acc_r;
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.data_in = d;
    acc_w = w && (model_q.size() < DEPTH);
    acc_r = r && (model_q.size() > 0);
    @(posedge clk);
    if (acc_r) begin
      exp_q.push_back(model_q.pop_front());
      rd_total++;
    end
    if (acc_w) begin
      model_q.push_back(d);
      wr_total++;
    end
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("empty", {31'd0, bus.empty}, {31'd0, model_q.size() == 0});
      check("full",  {31'd0, bus.full},  {31'd0, model_q.size() == DEPTH});
      check("wr_index", {28'd0, dut.wr_index}, wr_total % DEPTH);
      check("rd_index", {28'd0, dut.rd_index}, rd_total % DEPTH);
`ifdef SYNC_FIFO_FWFT_EN
      exp_q.delete();
      check("fwft_data", {16'd0, bus.data_out},
            (model_q.size() > 0) ? {16'd0, model_q[0]} : 32'd0);
`else
      if (exp_q.size() > 0) begin
        last_out = exp_q.pop_front();
        check("rd_data", {16'd0, bus.data_out}, {16'd0, last_out});
      end else begin
        check("hold_data", {16'd0, bus.data_out}, {16'd0, last_out});
      end
`endif
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    mon_en = 1'b0;
    model_reset();
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;

    // Reset held for more than 20 ns.
    reset_n = 1'b0;
    #22;
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_data", {16'd0, bus.data_out}, 32'd0);
    check("rst_wr_index", {28'd0, dut.wr_index}, 32'd0);
    check("rst_rd_index", {28'd0, dut.rd_index}, 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk);
    #1;

    // Fill 1..16, then an ignored 17th write.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, DW'(i));
    cycle(1'b1, 1'b0, 16'd99);
    // Drain 16, then an ignored 17th read.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    // Wrap: write 8, read 8, write 101..116 to full, read all back.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(200 + i));
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0);
    for (int i = 101; i <= 116; i++) cycle(1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0);

    // Simultaneous access from empty, then steady state, then on full.
    cycle(1'b1, 1'b1, 16'd1);
    for (int i = 2; i <= 8; i++) cycle(1'b1, 1'b1, DW'(i));
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, DW'(300 + i));
    cycle(1'b1, 1'b1, 16'd777);
    cycle(1'b1, 1'b1, 16'd778);
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, '0);

    // Randomized traffic with shifting read/write bias to visit full and empty.
    for (int ph = 0; ph < 6; ph++) begin
      int wp;
      wp = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
      for (int i = 0; i < 80; i++) begin
        cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
              DW'($urandom));
      end
    end

    // Reset mid-operation: 5 writes, then an asynchronous pulse between edges.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(50 + i));
    cycle(1'b0, 1'b1, '0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_empty", {31'd0, bus.empty}, 32'd1);
    check("arst_full", {31'd0, bus.full}, 32'd0);
    check("arst_wr_index", {28'd0, dut.wr_index}, 32'd0);
    check("arst_rd_index", {28'd0, dut.rd_index}, 32'd0);
    check("arst_data", {16'd0, bus.data_out}, 32'd0);
    model_reset();
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Post-reset operation resumes from address 0.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DW'(900 + i));
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
